// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit controller and its serializer.
package uart_tx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Frame sequencing states of the transmit controller.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Source selection for the registered serial line.
  typedef enum logic [1:0] {
    START_BIT,
    DATA_BIT,
    PAR_BIT,
    STOP_BIT
  } tx_sel_e;

  // Bit-counter width; a 1-bit payload still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter.
// serial_bit is the payload bit that belongs on the line in the coming cycle,
// so the controller can register it without an extra stage of latency.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  serial_bit,
  output logic                  done
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [DATA_WIDTH-1:0] shifted;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;

  // Load restarts the payload and clears the count, which then stays at zero
  // until the first DATA cycle; each DATA cycle consumes one bit.
  always_comb begin
    shifted = shift_q >> 1;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      shift_d = load_data;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = shifted;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Next line bit (look-ahead by one when shifting) and the last-bit flag.
  always_comb begin
    serial_bit = shift_en ? shifted[0] : shift_q[0];
    done       = (cnt_q == LAST_CNT);
  end

  // Shift register and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a parallel payload as start, LSB-first data,
// optional parity and stop bit, one bit per clock. tx_out is registered from the
// next-state selection so an accept at edge k shows the start bit in cycle k+1.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  parity_bit,
  output logic                  capture,
  output logic                  tx_out,
  output logic                  busy
);

  tx_state_e state_q;
  tx_state_e state_d;
  tx_sel_e   tx_sel;

  logic par_en_q;
  logic par_en_d;
  logic tx_out_q;
  logic tx_out_d;
  logic accept;
  logic ser_load;
  logic ser_shift;
  logic ser_bit;
  logic ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .shift_en  (ser_shift),
    .load_data (p_data),
    .serial_bit(ser_bit),
    .done      (ser_done)
  );

  // A request is taken only when the line is idle or finishing its stop bit.
  always_comb begin
    accept  = data_valid && ((state_q == IDLE) || (state_q == STOP));
    capture = accept && rst_n;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; STOP chains straight into START for back-to-back frames.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   state_d = DATA;
      DATA:    if (ser_done) state_d = par_en_q ? PARITY : STOP;
      PARITY:  state_d = STOP;
      STOP:    state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: line source for the coming cycle, serializer controls, busy.
  always_comb begin
    case (state_d)
      START:   tx_sel = START_BIT;
      DATA:    tx_sel = DATA_BIT;
      PARITY:  tx_sel = PAR_BIT;
      default: tx_sel = STOP_BIT;
    endcase
    ser_load  = accept;
    ser_shift = (state_q == DATA);
    busy      = (state_q != IDLE);
  end

  // Line mux and frame option latch; parity_bit is sampled on entry to PARITY.
  always_comb begin
    case (tx_sel)
      START_BIT: tx_out_d = 1'b0;
      DATA_BIT:  tx_out_d = ser_bit;
      PAR_BIT:   tx_out_d = parity_bit;
      default:   tx_out_d = 1'b1;
    endcase
    par_en_d = accept ? par_en : par_en_q;
  end

  // Registered line output and latched parity enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_out_q <= 1'b1;
      par_en_q <= 1'b0;
    end else begin
      tx_out_q <= tx_out_d;
      par_en_q <= par_en_d;
    end
  end

  assign tx_out = tx_out_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a queue-based line model plus directed
// frames with hand-computed bit patterns and a randomized traffic phase.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

   localparam int W = 8;
   localparam int LOG_DEPTH = 8192;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [W-1:0] p_data = '0;
   logic         data_valid = 1'b0;
   logic         par_en = 1'b0;
   logic         parity_bit;
   logic         capture;
   logic         tx_out;
   logic         busy;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic oddMode = 1'b0;
   logic calcReg;

   logic txLog   [LOG_DEPTH];
   logic busyLog [LOG_DEPTH];
   logic capLog  [LOG_DEPTH];

   // One expected line bit; last marks the stop bit, where a new request may be taken.
   typedef struct {
      logic tx;
      logic last;
   } lineBit_t;

   lineBit_t modelQ[$];

   uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .p_data    (p_data),
      .data_valid(data_valid),
      .par_en    (par_en),
      .parity_bit(parity_bit),
      .capture   (capture),
      .tx_out    (tx_out),
      .busy      (busy)
   );

   // Free-running bit clock.
   always #5 clk = ~clk;

   // External parity calculator: loads on capture, even or odd per oddMode.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) calcReg <= 1'b0;
      else if (capture) calcReg <= (^p_data) ^ oddMode;
   end
   assign parity_bit = calcReg;

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %b, wanted %b", name, cyc, actual, expected);
      end
   endtask

   task automatic checkCount(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
      end
   endtask

   // Line model: on an accepted request the whole frame is queued bit by bit,
   // one entry per future cycle; the head of the queue is the current cycle.
   initial forever begin
      logic acc;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         modelQ.delete();
      end else begin
         acc = data_valid && (modelQ.size() == 0 || modelQ[0].last);
         if (modelQ.size() != 0) void'(modelQ.pop_front());
         if (acc) begin
            modelQ.push_back('{tx: 1'b0, last: 1'b0});
            for (int i = 0; i < W; i++) modelQ.push_back('{tx: p_data[i], last: 1'b0});
            if (par_en) modelQ.push_back('{tx: (^p_data) ^ oddMode, last: 1'b0});
            modelQ.push_back('{tx: 1'b1, last: 1'b1});
         end
      end
   end

   // Mid-cycle compare of every output against the model, with a per-cycle log.
   initial forever begin
      logic expTx, expBusy, expCap;
      @(negedge clk);
      expTx   = 1'b1;
      expBusy = 1'b0;
      if (modelQ.size() != 0) begin
         expTx   = modelQ[0].tx;
         expBusy = 1'b1;
      end
      expCap = rst_n && data_valid && (modelQ.size() == 0 || modelQ[0].last);
      if (cyc < LOG_DEPTH) begin
         txLog[cyc]   = tx_out;
         busyLog[cyc] = busy;
         capLog[cyc]  = capture;
      end
      checkOutput("tx_out", tx_out, expTx);
      checkOutput("busy", busy, expBusy);
      checkOutput("capture", capture, expCap);
      cyc++;
   end

   // Drives one cycle of inputs shortly after the next rising edge.
   task automatic applyStimulus(input logic dv, input logic [W-1:0] d, input logic pe);
      @(posedge clk);
      #1;
      data_valid = dv;
      p_data     = d;
      par_en     = pe;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drops the request and waits (bounded) until the model line is idle.
   task automatic waitIdle();
      bit idle;
      idle = 0;
      data_valid = 1'b0;
      for (int i = 0; i < 100 && !idle; i++) begin
         waitCycles(1);
         if (modelQ.size() == 0) idle = 1;
      end
      if (!idle) checkCount("idle_timeout", 1, 0);
   endtask

   // Single-cycle request from idle; start is the log index of the start-bit cycle.
   task automatic sendFrame(input logic [W-1:0] d, input logic pe, output int start);
      applyStimulus(1'b1, d, pe);
      applyStimulus(1'b0, W'($urandom), 1'($urandom));
      start = cyc;
   endtask

   // Compares logged line bits against a hand-written pattern (leftmost = first cycle).
   task automatic checkFrame(input string name, input int start, input int len, input logic [0:15] expBits);
      for (int i = 0; i < len; i++) checkOutput(name, txLog[start + i], expBits[i]);
   endtask

   function automatic int countOnes(input int first, input int last, input int which);
      int n;
      n = 0;
      for (int i = first; i <= last; i++) begin
         if (which == 0) n += int'(busyLog[i]);
         else n += int'(capLog[i]);
      end
      return n;
   endfunction

   // Time limit so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios, then randomized traffic.
   initial begin
      int s, s2;
      data_valid = 1'b1;
      p_data     = 8'h33;
      par_en     = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_tx", tx_out, 1'b1);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_capture", capture, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      data_valid = 1'b0;

      $display("[TB] 0xA5 without parity");
      waitIdle();
      sendFrame(8'hA5, 1'b0, s);
      waitCycles(12);
      checkFrame("a5_frame", s, 10, 16'b0101001011000000);
      checkCount("a5_busy_len", countOnes(s - 1, s + 11, 0), 10);

      $display("[TB] 0xA5 with even and odd parity");
      waitIdle();
      oddMode = 1'b0;
      sendFrame(8'hA5, 1'b1, s);
      waitCycles(13);
      checkOutput("a5_even_par", txLog[s + 9], 1'b0);
      checkFrame("a5_even_frame", s, 11, 16'b0101001010100000);
      checkCount("a5_even_busy_len", countOnes(s - 1, s + 12, 0), 11);
      waitIdle();
      oddMode = 1'b1;
      sendFrame(8'hA5, 1'b1, s);
      waitCycles(13);
      checkOutput("a5_odd_par", txLog[s + 9], 1'b1);
      checkFrame("a5_odd_frame", s, 11, 16'b0101001011100000);
      checkCount("a5_odd_busy_len", countOnes(s - 1, s + 12, 0), 11);

      $display("[TB] back-to-back 0x01 then 0x80");
      waitIdle();
      applyStimulus(1'b1, 8'h01, 1'b0);
      applyStimulus(1'b1, 8'h80, 1'b0);
      s = cyc;
      waitCycles(9);
      applyStimulus(1'b0, 8'h00, 1'b0);
      waitCycles(12);
      checkFrame("b2b_first", s, 10, 16'b0100000001000000);
      checkFrame("b2b_second", s + 10, 10, 16'b0000000011000000);
      checkOutput("b2b_cap_idle", capLog[s - 1], 1'b1);
      checkOutput("b2b_cap_stop", capLog[s + 9], 1'b1);
      checkCount("b2b_cap_total", countOnes(s, s + 19, 1), 1);
      checkCount("b2b_busy_len", countOnes(s, s + 20, 0), 20);

      $display("[TB] request during DATA of 0x3C");
      waitIdle();
      sendFrame(8'h3C, 1'b0, s);
      applyStimulus(1'b1, 8'hC3, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      waitCycles(10);
      checkFrame("ignore_frame", s, 10, 16'b0001111001000000);
      checkCount("ignore_cap_total", countOnes(s, s + 11, 1), 0);
      checkCount("ignore_busy_len", countOnes(s, s + 11, 0), 10);

      $display("[TB] reset during 4th data bit");
      waitIdle();
      sendFrame(8'hE7, 1'b0, s);
      waitCycles(4);
      data_valid = 1'b1;
      p_data     = 8'h5A;
      par_en     = 1'b0;
      rst_n      = 1'b0;
      #1;
      checkOutput("midrst_tx", tx_out, 1'b1);
      checkOutput("midrst_busy", busy, 1'b0);
      checkOutput("midrst_capture", capture, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b0, W'($urandom), 1'b0);
      s2 = cyc;
      waitCycles(11);
      checkOutput("post_rst_idle_before", txLog[s2 - 1], 1'b1);
      checkFrame("post_rst_frame", s2, 10, 16'b0010110101000000);

      $display("[TB] 0xFF then 0x00 with odd parity");
      waitIdle();
      oddMode = 1'b1;
      sendFrame(8'hFF, 1'b1, s);
      waitCycles(13);
      checkOutput("ff_odd_par", txLog[s + 9], 1'b1);
      checkFrame("ff_frame", s, 11, 16'b0111111111100000);
      waitIdle();
      sendFrame(8'h00, 1'b1, s);
      waitCycles(13);
      checkOutput("zero_odd_par", txLog[s + 9], 1'b1);
      checkFrame("zero_frame", s, 11, 16'b0000000001100000);

      $display("[TB] randomized traffic");
      for (int blk = 0; blk < 4; blk++) begin
         waitIdle();
         oddMode = 1'($urandom_range(0, 1));
         for (int i = 0; i < 150; i++) begin
            applyStimulus(1'($urandom_range(0, 9) < 4), W'($urandom), 1'($urandom));
            if (blk == 2 && i == 70) begin
               rst_n = 1'b0;
               #2;
               rst_n = 1'b1;
            end
         end
      end
      waitIdle();
      waitCycles(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
